// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI RAM slave: channel FSM states and
// the AXI response and burst encodings.
package axi_ram_pkg;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DATA  = 2'd1,
    W_DELAY = 2'd2,
    W_RESP  = 2'd3
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DELAY = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  localparam int unsigned RESP_OKAY  = 0;
  localparam logic [1:0]  BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_ram_mem.sv
// Byte-enabled word array with one strobed write port and one asynchronous
// read port. Synchronous reset clears every word.
module axi_ram_mem
  import axi_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned MEM_ADDR_SIZE = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [MEM_ADDR_SIZE-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [STROBE_WIDTH-1:0]  wstrb_i,
  input  logic [MEM_ADDR_SIZE-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_SIZE;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned k = 0; k < STROBE_WIDTH; k++) begin
        if (wstrb_i[k]) begin
          mem_q[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end
    end
  end

  // Reads see the array before this cycle's write lands (old data on collision).
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4-style RAM slave: independent write (AW/W/B) and read (AR/R) FSMs in
// front of a byte-enabled word array. INCR bursts only; other burst types act as INCR.
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned BRESP_WIDTH   = 3,
  parameter int unsigned WR_MEM_DELAY  = 0,
  parameter int unsigned RD_MEM_DELAY  = 0,
  parameter int unsigned STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned MEM_ADDR_SIZE = ADDR_WIDTH - $clog2(STROBE_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,

  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STROBE_WIDTH-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,

  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [BRESP_WIDTH-1:0]  s_axi_bresp,

  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,

  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [BRESP_WIDTH-1:0]  s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int unsigned LG = $clog2(STROBE_WIDTH);

  // Write channel state
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic [31:0]           wdly_q, wdly_d;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] winc;

  // Read channel state
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic [31:0]           rdly_q, rdly_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rd_load;
  logic [ADDR_WIDTH-1:0] rinc;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awburst == BURST_INCR, s_axi_arburst, s_axi_wlast};

  assign winc = ADDR_WIDTH'(1) << awsize_q;
  assign rinc = ADDR_WIDTH'(1) << arsize_q;

  axi_ram_mem #(
    .DATA_WIDTH   (DATA_WIDTH),
    .STROBE_WIDTH (STROBE_WIDTH),
    .MEM_ADDR_SIZE(MEM_ADDR_SIZE)
  ) u_mem (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .we_i   (mem_we),
    .waddr_i(waddr_q[ADDR_WIDTH-1:LG]),
    .wdata_i(s_axi_wdata),
    .wstrb_i(s_axi_wstrb),
    .raddr_i(rd_addr[ADDR_WIDTH-1:LG]),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    w_state_d     = w_state_q;
    awid_d        = awid_q;
    waddr_d       = waddr_q;
    awlen_d       = awlen_q;
    awsize_d      = awsize_q;
    wcnt_d        = wcnt_q;
    wdly_d        = wdly_q;
    mem_we        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          awid_d    = s_axi_awid;
          waddr_d   = s_axi_awaddr;
          awlen_d   = s_axi_awlen;
          awsize_d  = s_axi_awsize;
          wcnt_d    = '0;
          wdly_d    = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_we  = 1'b1;
          waddr_d = waddr_q + winc;
          wcnt_d  = wcnt_q + 8'd1;
          // Beat count alone ends the burst; wlast plays no part.
          if (wcnt_q == awlen_q) begin
            wdly_d    = '0;
            w_state_d = (WR_MEM_DELAY > 0) ? W_DELAY : W_RESP;
          end
        end
      end
      W_DELAY: begin
        wdly_d = wdly_q + 32'd1;
        if (wdly_q == 32'(WR_MEM_DELAY - 1)) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi_bid   = awid_q;
  assign s_axi_bresp = BRESP_WIDTH'(RESP_OKAY);

  always_comb begin
    r_state_d     = r_state_q;
    arid_d        = arid_q;
    raddr_d       = raddr_q;
    arlen_d       = arlen_q;
    arsize_d      = arsize_q;
    rcnt_d        = rcnt_q;
    rdly_d        = rdly_q;
    rd_load       = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          arid_d   = s_axi_arid;
          raddr_d  = s_axi_araddr;
          arlen_d  = s_axi_arlen;
          arsize_d = s_axi_arsize;
          rcnt_d   = '0;
          rdly_d   = '0;
          if (RD_MEM_DELAY > 0) begin
            r_state_d = R_DELAY;
          end else begin
            r_state_d = R_DATA;
            rd_load   = 1'b1;
          end
        end
      end
      R_DELAY: begin
        rdly_d = rdly_q + 32'd1;
        if (rdly_q == 32'(RD_MEM_DELAY - 1)) begin
          r_state_d = R_DATA;
          rd_load   = 1'b1;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          if (rcnt_q == arlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d = raddr_q + rinc;
            rcnt_d  = rcnt_q + 8'd1;
            rd_load = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read address tracks whichever beat is about to be captured into rdata_q,
  // keeping the memory read path independent of the FSM decode.
  always_comb begin
    rd_addr = raddr_q;
    if (r_state_q == R_IDLE) begin
      rd_addr = s_axi_araddr;
    end else if (r_state_q == R_DATA) begin
      rd_addr = raddr_q + rinc;
    end
  end

  assign rdata_d = rd_load ? mem_rdata : rdata_q;

  assign s_axi_rid   = arid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = BRESP_WIDTH'(RESP_OKAY);
  assign s_axi_rlast = (r_state_q == R_DATA) && (rcnt_q == arlen_q);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      wcnt_q    <= '0;
      wdly_q    <= '0;
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      rcnt_q    <= '0;
      rdly_q    <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      wcnt_q    <= wcnt_d;
      wdly_q    <= wdly_d;
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      raddr_q   <= raddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      rcnt_q    <= rcnt_d;
      rdly_q    <= rdly_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: a zero-delay instance for burst traffic
// and a delayed instance for response latency.
module tb_axi_ram_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0;
  logic        bvalid, bready = 1, arvalid = 0, arready, rvalid, rready = 1, rlast;
  logic [3:0]  awid = 0, awaddr = 0, bid, arid = 0, araddr = 0, rid;
  logic [7:0]  awlen = 0, arlen = 0;
  logic [2:0]  awsize = 0, arsize = 0, bresp, rresp;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01, wstrb = 0;
  logic [15:0] wdata = 0, rdata;

  logic        d_awvalid = 0, d_awready, d_wvalid = 0, d_wready, d_wlast = 0;
  logic        d_bvalid, d_arvalid = 0, d_arready, d_rvalid, d_rlast;
  logic [3:0]  d_awid = 0, d_awaddr = 0, d_bid, d_arid = 0, d_araddr = 0, d_rid;
  logic [7:0]  d_awlen = 0, d_arlen = 0;
  logic [2:0]  d_awsize = 0, d_arsize = 0, d_bresp, d_rresp;
  logic [1:0]  d_wstrb = 0;
  logic [15:0] d_wdata = 0, d_rdata;

  axi_ram_slave u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid),
    .s_axi_bresp(bresp), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rlast(rlast)
  );

  axi_ram_slave #(.WR_MEM_DELAY(3), .RD_MEM_DELAY(2)) u_dly (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(d_awvalid), .s_axi_awready(d_awready), .s_axi_awid(d_awid),
    .s_axi_awaddr(d_awaddr), .s_axi_awlen(d_awlen), .s_axi_awsize(d_awsize),
    .s_axi_awburst(2'b01), .s_axi_wvalid(d_wvalid), .s_axi_wready(d_wready),
    .s_axi_wdata(d_wdata), .s_axi_wstrb(d_wstrb), .s_axi_wlast(d_wlast),
    .s_axi_bvalid(d_bvalid), .s_axi_bready(1'b1), .s_axi_bid(d_bid),
    .s_axi_bresp(d_bresp), .s_axi_arvalid(d_arvalid), .s_axi_arready(d_arready),
    .s_axi_arid(d_arid), .s_axi_araddr(d_araddr), .s_axi_arlen(d_arlen),
    .s_axi_arsize(d_arsize), .s_axi_arburst(2'b01), .s_axi_rvalid(d_rvalid),
    .s_axi_rready(1'b1), .s_axi_rid(d_rid), .s_axi_rdata(d_rdata),
    .s_axi_rresp(d_rresp), .s_axi_rlast(d_rlast)
  );

  typedef struct {
    logic [3:0]  id;
    logic [15:0] data;
    logic        last;
  } rbeat_t;

  typedef logic [15:0] dv_t [8];
  typedef logic [1:0]  sv_t [8];

  int     errors = 0;
  int     checks = 0;
  rbeat_t rq[$];
  logic [3:0] bq[$];
  logic   rtoggle = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no handshake expected one", nm);
  endtask

  // Scoreboard monitor: pops expected responses as the DUT presents them.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          timeout("b_unexpected");
        end else begin
          chk("bid", bid, bq.pop_front());
          chk("bresp", bresp, 0);
        end
      end
      if (rvalid) begin
        if (rq.size() == 0) begin
          timeout("r_unexpected");
        end else if (rready) begin
          rbeat_t e;
          e = rq.pop_front();
          chk("rdata", rdata, e.data);
          chk("rid", rid, e.id);
          chk("rlast", rlast, e.last);
          chk("rresp", rresp, 0);
        end else begin
          chk("rdata_stall", rdata, rq[0].data);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rready = rtoggle ? ~rready : 1'b1;
  end

  function automatic logic rdy(input int w);
    case (w)
      0:       return awready;
      1:       return wready;
      default: return arready;
    endcase
  endfunction

  task automatic wait_hs(input int w, input string nm);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (rdy(w)) break;
      n++;
      if (n > 50) begin
        timeout(nm);
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] id, input logic [3:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst,
                    input dv_t d, input sv_t s, input bit good_last);
    bq.push_back(id);
    awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    wait_hs(0, "aw_hs");
    awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = d[i]; wstrb = s[i];
      wlast = good_last && (i == int'(len));
      wait_hs(1, "w_hs");
    end
    wvalid = 0;
    wlast  = 0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [3:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input dv_t d);
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{id: id, data: d[i], last: (i == int'(len))});
    end
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = size;
    wait_hs(2, "ar_hs");
    arvalid = 0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (bq.size() != 0 || rq.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 200) begin
        timeout(nm);
        bq.delete();
        rq.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    dv_t zeros, d1, d2, dw;
    sv_t s1, s3;
    int n;
    zeros = '{default: 16'h0};
    s1 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    s3 = '{default: 2'b11};

    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rlast", rlast, 0);

    rd(4'd1, 4'd0, 8'd7, 3'd1, zeros);
    drain("rd_zero");

    d1 = '{16'h0a0b, 16'h0a0b, 16'h0c0d, 16'h0c0d, 16'h0c0d, 16'h0, 16'h0, 16'h0};
    wr(4'd2, 4'd0, 8'd4, 3'd0, 2'b01, d1, s1, 1'b1);
    drain("wr1");
    d2 = '{16'h1213, 16'h1213, 16'h1415, 16'h1415, 16'h1415, 16'h0, 16'h0, 16'h0};
    wr(4'd2, 4'd8, 8'd4, 3'd0, 2'b01, d2, s1, 1'b1);
    drain("wr2");

    rd(4'd2, 4'd0, 8'd4, 3'd0,
       '{16'h0a0b, 16'h0a0b, 16'h0c0d, 16'h0c0d, 16'h000d, 16'h0, 16'h0, 16'h0});
    drain("rd1");
    rd(4'd3, 4'd8, 8'd2, 3'd1,
       '{16'h1213, 16'h1415, 16'h0015, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    drain("rd2");

    // FIXED burst with wlast never set, wrapping past the top of the address space
    dw = '{16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    wr(4'd5, 4'd14, 8'd2, 3'd1, 2'b00, dw, s3, 1'b0);
    drain("wr_wrap");
    rd(4'd5, 4'd14, 8'd2, 3'd1, dw);
    drain("rd_wrap");

    bready = 0;
    wr(4'd9, 4'd4, 8'd0, 3'd1, 2'b01, '{16'hbeef, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
       s3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bstall_bvalid", bvalid, 1);
      chk("bstall_awready", awready, 0);
    end
    @(posedge clk);
    #1 bready = 1;
    drain("wr_stall");

    rtoggle = 1;
    rd(4'd6, 4'd0, 8'd4, 3'd1,
       '{16'h2222, 16'h3333, 16'hbeef, 16'h0000, 16'h1213, 16'h0, 16'h0, 16'h0});
    drain("rd_stall");
    rtoggle = 0;

    d_awvalid = 1; d_awid = 4'd7; d_awaddr = 4'd2; d_awlen = 0; d_awsize = 3'd1;
    @(posedge clk);
    #1 d_awvalid = 0;
    d_wvalid = 1; d_wdata = 16'h5a5a; d_wstrb = 2'b11; d_wlast = 1;
    chk("dly_wready", d_wready, 1);
    @(posedge clk);
    #1 d_wvalid = 0; d_wlast = 0;
    n = 0;
    while (!d_bvalid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("dly_b_latency", n, 3);
    chk("dly_bid", d_bid, 7);
    chk("dly_bresp", d_bresp, 0);
    @(posedge clk);
    #1;
    d_arvalid = 1; d_arid = 4'd6; d_araddr = 4'd2; d_arlen = 0; d_arsize = 3'd1;
    @(posedge clk);
    #1 d_arvalid = 0;
    n = 0;
    while (!d_rvalid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("dly_r_latency", n, 2);
    chk("dly_rdata", d_rdata, 16'h5a5a);
    chk("dly_rid", d_rid, 6);
    chk("dly_rlast", d_rlast, 1);
    chk("dly_rresp", d_rresp, 0);
    @(posedge clk);
    #1 chk("dly_rvalid_done", d_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
